ff_bank_sequencer: RTL and testbench

Sequencer and arbiter for a bank of positive-edge D flip-flops with asynchronous active-low preset/clear (the dual-DFF flag/register parts used across the TTL datapath). Up to REQ requesters ask for load, preset or clear operations on a masked subset of the bank. The block grants one request at a time, round-robin. It drives D, the clock enable, Preset_bar and Clear_bar with guaranteed pulse width and recovery spacing, so the bank never sees overlapping async and clocked operations or the both-low state.

---
 rtl/ff_bank_sequencer_pkg.sv | 21 ++
 rtl/ff_bank_sequencer_if.sv | 24 ++
 rtl/ff_bank_sequencer_rr_arbiter.sv | 46 ++++
 rtl/ff_bank_sequencer.sv | 128 ++++++++++++
 tb/tb_ff_bank_sequencer.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ff_bank_sequencer_pkg.sv
// Shared types and constants for the flip-flop bank sequencer.
package ff_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_PULSE   = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_PRESET  = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ff_bank_sequencer_if.sv
// Request bus from REQ requesters to the sequencer.
// Handshake: a requester raises Req_valid[i] with op/mask/data stable and holds
// them until it sees Req_ready[i] high for one cycle; the request is taken on
// the rising edge that ends that cycle. Dropping valid earlier withdraws it.
interface ff_bank_sequencer_if #(
  parameter int BLOCKS = 2,
  parameter int REQ    = 4
);
  logic [REQ-1:0]        Req_valid;
  logic [2*REQ-1:0]      Req_op;
  logic [BLOCKS*REQ-1:0] Req_mask;
  logic [BLOCKS*REQ-1:0] Req_data;
  logic [REQ-1:0]        Req_ready;

  modport master (
    output Req_valid, Req_op, Req_mask, Req_data,
    input  Req_ready
  );

  modport slave (
    input  Req_valid, Req_op, Req_mask, Req_data,
    output Req_ready
  );
endinterface

// File: rtl/ff_bank_sequencer_rr_arbiter.sv
// Round-robin arbiter: the pointer names the highest-priority requester and
// moves past the winner on every accepted grant.
module rr_arbiter #(
  parameter int REQ = 4,
  localparam int PW = (REQ > 1) ? $clog2(REQ) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [REQ-1:0] valid,
  input  logic           accept,
  output logic [REQ-1:0] grant,
  output logic [PW-1:0]  grant_idx,
  output logic           any
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= REQ) idx = idx - REQ;
      cand = PW'(idx);
      if (!any && valid[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept && any) begin
      ptr <= (grant_idx == PW'(REQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/ff_bank_sequencer.sv
// Arbitrates load/preset/clear requests and sequences them onto a bank of
// async-preset/clear D flip-flops with safe pulse width and recovery spacing.
module ff_bank_sequencer
  import ff_seq_pkg::*;
#(
  parameter int BLOCKS          = 2,
  parameter int REQ             = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                Clk,
  input  logic                Clear,
  ff_bank_sequencer_if.slave  req,
  output logic                Err,
  output logic                Done,
  output logic                Busy,
  output logic [BLOCKS-1:0]   D,
  output logic [BLOCKS-1:0]   Clk_en,
  output logic [BLOCKS-1:0]   Preset_bar,
  output logic [BLOCKS-1:0]   Clear_bar,
  output state_t              dbg_state
);

  localparam int PW      = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int CNT_MAX = max2(PULSE_CYCLES, RECOVERY_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] REC_LAST   = CW'(RECOVERY_CYCLES - 1);

  state_t            state, next_state;
  logic [CW-1:0]     cnt;
  logic              boot;
  logic [1:0]        op_q;
  logic [BLOCKS-1:0] mask_q;
  logic [BLOCKS-1:0] d_q;

  logic [REQ-1:0]    grant;
  logic [PW-1:0]     gidx;
  logic              any;
  logic              accept;
  logic [1:0]        op_sel;
  logic [BLOCKS-1:0] mask_sel;
  logic [BLOCKS-1:0] data_sel;
  logic              rec_last;

  assign accept = (state == ST_IDLE) && any;

  rr_arbiter #(.REQ(REQ)) u_arb (
    .clk       (Clk),
    .rst       (Clear),
    .valid     (req.Req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (gidx),
    .any       (any)
  );

  always_comb begin
    op_sel   = req.Req_op[2*int'(gidx) +: 2];
    mask_sel = req.Req_mask[BLOCKS*int'(gidx) +: BLOCKS];
    data_sel = req.Req_data[BLOCKS*int'(gidx) +: BLOCKS];
  end

  // boot holds the bank cleared while reset is applied, then lets one
  // RECOVER pass run with Clear_bar released before IDLE.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state <= ST_RECOVER;
      boot  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= next_state;
      boot  <= 1'b0;
      if (boot || next_state != state) begin
        cnt <= '0;
      end else if (state == ST_PULSE || state == ST_RECOVER) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      op_q   <= OP_LOAD;
      mask_q <= '0;
      d_q    <= '0;
    end else if (accept) begin
      op_q   <= op_sel;
      mask_q <= mask_sel;
      if (op_sel == OP_LOAD) d_q <= (d_q & ~mask_sel) | (data_sel & mask_sel);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (any && op_sel != OP_ILLEGAL && mask_sel != '0) begin
          next_state = (op_sel == OP_LOAD) ? ST_SETUP : ST_PULSE;
        end
      end
      ST_SETUP:   next_state = ST_STROBE;
      ST_STROBE:  next_state = ST_IDLE;
      ST_PULSE:   if (cnt == PULSE_LAST) next_state = ST_RECOVER;
      ST_RECOVER: if (!boot && cnt == REC_LAST) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Only the line matching the latched op can go low, so preset and clear
  // never overlap on a bit.
  always_comb begin
    rec_last      = (state == ST_RECOVER) && !boot && (cnt == REC_LAST);
    req.Req_ready = accept ? grant : '0;
    Err           = accept && (op_sel == OP_ILLEGAL);
    Done          = (accept && (op_sel == OP_ILLEGAL || mask_sel == '0))
                  || (state == ST_STROBE)
                  || (rec_last && (op_q == OP_PRESET || op_q == OP_CLEAR));
    Busy          = (state != ST_IDLE);
    D             = d_q;
    Clk_en        = (state == ST_STROBE) ? mask_q : '0;
    Preset_bar    = (state == ST_PULSE && op_q == OP_PRESET) ? ~mask_q : '1;
    Clear_bar     = boot ? '0
                  : (state == ST_PULSE && op_q == OP_CLEAR) ? ~mask_q : '1;
    dbg_state     = state;
  end

endmodule

// File: tb/tb_ff_bank_sequencer.sv
// Self-checking bench for ff_bank_sequencer: reset, load, preset, round-robin,
// illegal/empty requests and abort by reset.
module tb_ff_bank_sequencer;
  import ff_seq_pkg::*;

  localparam int BLOCKS = 2;
  localparam int REQ    = 4;
  localparam int W      = REQ + 2;

  logic        Clk = 1'b0;
  logic        Clear;
  logic        Err, Done, Busy;
  logic [1:0]  D, Clk_en, Preset_bar, Clear_bar;
  state_t      dbg_state;

  ff_bank_sequencer_if #(.BLOCKS(BLOCKS), .REQ(REQ)) bus ();

  ff_bank_sequencer #(
    .BLOCKS(BLOCKS), .REQ(REQ), .PULSE_CYCLES(2), .RECOVERY_CYCLES(1)
  ) dut (
    .Clk        (Clk),
    .Clear      (Clear),
    .req        (bus),
    .Err        (Err),
    .Done       (Done),
    .Busy       (Busy),
    .D          (D),
    .Clk_en     (Clk_en),
    .Preset_bar (Preset_bar),
    .Clear_bar  (Clear_bar),
    .dbg_state  (dbg_state)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int               n_checks = 0;
  int               n_pass   = 0;
  logic [W-1:0]     exp_q[$];
  logic [1:0]       d_model;
  logic [1:0]       both_low;
  int               dones;
  logic [1:0]       rr_m [4] = '{2'b11, 2'b01, 2'b10, 2'b10};
  logic [1:0]       rr_d [4] = '{2'b00, 2'b01, 2'b10, 2'b00};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // preset and clear must never be low on the same bit outside reset
  always @(negedge Clk) begin
    if (Clear === 1'b0) begin
      both_low = ~Preset_bar & ~Clear_bar;
      check("no_both_low", both_low, 2'b00);
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [1:0] op, input logic [1:0] m,
                           input logic [1:0] d);
    bus.Req_valid[i]        = 1'b1;
    bus.Req_op[2*i +: 2]    = op;
    bus.Req_mask[2*i +: 2]  = m;
    bus.Req_data[2*i +: 2]  = d;
  endtask

  task automatic drop_req(input int i);
    bus.Req_valid[i] = 1'b0;
  endtask

  task automatic push_grant(input int i, input logic err, input logic done);
    logic [REQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    exp_q.push_back({oh, err, done});
  endtask

  // scoreboard: wait for the next accept strobe and compare with the queue head
  task automatic expect_grant(input string tag);
    logic [W-1:0] obs, e;
    bit got;
    got = 1'b0;
    obs = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge Clk);
      if (bus.Req_ready != '0) begin
        got = 1'b1;
        obs = {bus.Req_ready, Err, Done};
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, obs, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic wait_idle(input string tag, output int n_done);
    bit idle;
    idle   = 1'b0;
    n_done = 0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge Clk);
      if (Done) n_done++;
      if (!Busy) idle = 1'b1;
    end
    if (!idle) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    Clear         = 1'b1;
    bus.Req_valid = '0;
    bus.Req_op    = '0;
    bus.Req_mask  = '0;
    bus.Req_data  = '0;
    d_model       = 2'b00;

    // reset held for three cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check("rst_clear_bar", Clear_bar, 2'b00);
      check("rst_busy", Busy, 1'b1);
    end
    check("rst_preset_bar", Preset_bar, 2'b11);
    check("rst_d", D, 2'b00);
    check("rst_clk_en", Clk_en, 2'b00);
    check("rst_done", Done, 1'b0);
    check("rst_err", Err, 1'b0);
    check("rst_ready", bus.Req_ready, 4'b0000);
    Clear = 1'b0;
    @(negedge Clk);
    check("rec_busy", Busy, 1'b1);
    check("rec_clear_bar", Clear_bar, 2'b11);
    check("rec_clk_en", Clk_en, 2'b00);
    check("rec_done", Done, 1'b0);
    @(negedge Clk);
    check("idle_busy", Busy, 1'b0);

    // round-robin: all four requesters hold loads, five grants
    next_cycle();
    for (int i = 0; i < REQ; i++) drive_req(i, OP_LOAD, rr_m[i], rr_d[i]);
    push_grant(0, 1'b0, 1'b0);
    push_grant(1, 1'b0, 1'b0);
    push_grant(2, 1'b0, 1'b0);
    push_grant(3, 1'b0, 1'b0);
    push_grant(0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      expect_grant("rr_grant");
      d_model = (d_model & ~rr_m[k % REQ]) | (rr_d[k % REQ] & rr_m[k % REQ]);
      next_cycle();
      if (k == 4) for (int i = 0; i < REQ; i++) drop_req(i);
      @(negedge Clk);
      check("rr_d", D, d_model);
    end
    wait_idle("rr_idle", dones);

    // load on requester 0
    next_cycle();
    drive_req(0, OP_LOAD, 2'b11, 2'b10);
    push_grant(0, 1'b0, 1'b0);
    expect_grant("load_grant");
    next_cycle();
    drop_req(0);
    d_model = 2'b10;
    @(negedge Clk);
    check("load_d", D, d_model);
    check("load_setup_clk_en", Clk_en, 2'b00);
    check("load_setup_done", Done, 1'b0);
    @(negedge Clk);
    check("load_clk_en", Clk_en, 2'b11);
    check("load_done", Done, 1'b1);
    check("load_d_hold", D, d_model);
    @(negedge Clk);
    check("load_idle", Busy, 1'b0);
    check("load_clk_en_off", Clk_en, 2'b00);

    // preset on requester 2
    next_cycle();
    drive_req(2, OP_PRESET, 2'b01, 2'b11);
    push_grant(2, 1'b0, 1'b0);
    expect_grant("preset_grant");
    next_cycle();
    drop_req(2);
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      check("preset_pulse", Preset_bar, 2'b10);
      check("preset_clear_bar", Clear_bar, 2'b11);
      check("preset_pulse_done", Done, 1'b0);
    end
    @(negedge Clk);
    check("preset_released", Preset_bar, 2'b11);
    check("preset_rec_done", Done, 1'b1);
    check("preset_rec_busy", Busy, 1'b1);
    check("preset_d", D, d_model);
    @(negedge Clk);
    check("preset_idle", Busy, 1'b0);

    // illegal op on requester 1
    next_cycle();
    drive_req(1, OP_ILLEGAL, 2'b11, 2'b01);
    push_grant(1, 1'b1, 1'b1);
    expect_grant("illegal_grant");
    check("illegal_preset_bar", Preset_bar, 2'b11);
    check("illegal_clear_bar", Clear_bar, 2'b11);
    check("illegal_clk_en", Clk_en, 2'b00);
    next_cycle();
    drop_req(1);
    @(negedge Clk);
    check("illegal_idle", Busy, 1'b0);
    check("illegal_err_pulse", Err, 1'b0);
    check("illegal_d", D, d_model);

    // empty mask on requester 3
    next_cycle();
    drive_req(3, OP_LOAD, 2'b00, 2'b11);
    push_grant(3, 1'b0, 1'b1);
    expect_grant("empty_grant");
    check("empty_clk_en", Clk_en, 2'b00);
    check("empty_clear_bar", Clear_bar, 2'b11);
    next_cycle();
    drop_req(3);
    @(negedge Clk);
    check("empty_idle", Busy, 1'b0);
    check("empty_d", D, d_model);
    check("empty_clk_en_after", Clk_en, 2'b00);

    // abort a clear operation during its pulse
    next_cycle();
    drive_req(0, OP_CLEAR, 2'b11, 2'b00);
    push_grant(0, 1'b0, 1'b0);
    expect_grant("abort_grant");
    next_cycle();
    drop_req(0);
    @(negedge Clk);
    check("abort_pulse", Clear_bar, 2'b00);
    Clear = 1'b1;
    d_model = 2'b00;
    #1;
    check("abort_d", D, d_model);
    check("abort_busy", Busy, 1'b1);
    check("abort_done", Done, 1'b0);
    check("abort_preset_bar", Preset_bar, 2'b11);
    check("abort_clear_bar", Clear_bar, 2'b00);
    dones = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      if (Done) dones++;
    end
    Clear = 1'b0;
    begin
      int more;
      wait_idle("abort_idle", more);
      dones += more;
    end
    check("abort_no_done", dones, 0);

    // normal service after the abort
    next_cycle();
    drive_req(1, OP_LOAD, 2'b01, 2'b01);
    push_grant(1, 1'b0, 1'b0);
    expect_grant("post_grant");
    next_cycle();
    drop_req(1);
    d_model = 2'b01;
    @(negedge Clk);
    check("post_d", D, d_model);
    @(negedge Clk);
    check("post_clk_en", Clk_en, 2'b01);
    check("post_done", Done, 1'b1);
    @(negedge Clk);
    check("post_idle", Busy, 1'b0);

    check("sb_empty", exp_q.size(), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
